pipe_alu_core: RTL and testbench

Parametrised four-stage register-to-register ALU pipeline: operand read, execute, register writeback and memory store. It is the successor to the fixed 16-bit, two-phase-clock pipeline example. Changes from that design: one clock, asynchronous reset, a valid/stall handshake, full operand forwarding (no RAW hazards), per-instruction write enables, an immediate load, status flags, and debug read ports on the register bank and data memory.

---
 rtl/pipe_alu_pkg.sv | 85 ++++++++
 rtl/pipe_alu_exec.sv | 20 ++
 rtl/pipe_alu_core.sv | 104 ++++++++++
 tb/tb_pipe_alu_core.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_alu_pkg.sv
// pipe_alu_pkg: opcodes, flag bit positions and the width-generic ALU function alu_eval(func, a, b, imm, dw) -> {result, flags, illegal}
package pipe_alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_PASSA = 4'd3;
  localparam logic [3:0] OP_PASSB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NEGA = 4'd8;
  localparam logic [3:0] OP_NEGB = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SLL = 4'd11;
  localparam logic [3:0] OP_LDI = 4'd12;
  localparam int FL_C = 3;
  localparam int FL_V = 2;
  localparam int FL_N = 1;
  localparam int FL_Z = 0;
  localparam int MAXW = 64;
  typedef logic [MAXW-1:0] word_t;
  typedef struct packed {
    word_t result;
    logic [3:0] flags;
    logic illegal;
  } alu_out_t;
  function automatic alu_out_t alu_eval(input logic [3:0] func, input word_t a, input word_t b, input word_t imm, input int dw);
    word_t m, am, bm, r;
    logic [MAXW:0] s;
    logic c, v, sa, sb, sr, il;
    alu_out_t o;
    m = (dw >= MAXW) ? '1 : (word_t'(1) << dw) - word_t'(1);
    am = a & m;
    bm = b & m;
    s = '0;
    r = '0;
    c = 1'b0;
    il = 1'b0;
    sa = |(am & (word_t'(1) << (dw - 1)));
    sb = |(bm & (word_t'(1) << (dw - 1)));
    case (func)
      OP_ADD: begin
        s = {1'b0, am} + {1'b0, bm};
        r = s[MAXW-1:0];
        c = |(s >> dw);
      end
      OP_SUB: begin
        r = am - bm;
        c = am < bm;
      end
      OP_MUL: r = am * bm;
      OP_PASSA: r = am;
      OP_PASSB: r = bm;
      OP_AND: r = am & bm;
      OP_OR: r = am | bm;
      OP_XOR: r = am ^ bm;
      OP_NEGA: r = -am;
      OP_NEGB: r = -bm;
      OP_SRL: begin
        r = am >> 1;
        c = am[0];
      end
      OP_SLL: begin
        r = am << 1;
        c = sa;
      end
      OP_LDI: r = imm;
      default: il = 1'b1;
    endcase
    r = r & m;
    sr = |(r & (word_t'(1) << (dw - 1)));
    v = (func == OP_ADD) ? (sa == sb && sr != sa) :
        (func == OP_SUB) ? (sa != sb && sr != sa) :
        (func == OP_NEGA) ? (sa && sr) :
        (func == OP_NEGB) ? (sb && sr) : 1'b0;
    o.result = r;
    o.flags = '0;
    o.flags[FL_C] = c;
    o.flags[FL_V] = v;
    o.flags[FL_N] = sr;
    o.flags[FL_Z] = (r == '0);
    o.illegal = il;
    return o;
  endfunction
endpackage

// File: rtl/pipe_alu_exec.sv
// pipe_alu_exec: combinational DW-bit ALU; in func/a/b/imm, out y/flags {C,V,N,Z}/illegal
module pipe_alu_exec
  import pipe_alu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    func,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] y,
  output logic [3:0]    flags,
  output logic          illegal
);
  alu_out_t o;
  assign o = alu_eval(func, word_t'(a), word_t'(b), word_t'(imm), DW);
  assign y = DW'(o.result);
  assign flags = o.flags;
  assign illegal = o.illegal;
endmodule

// File: rtl/pipe_alu_core.sv
// pipe_alu_core: 4-stage forwarding ALU pipeline; in clk/rst/in_valid/stall/rs1/rs2/rd/func/addr/wr_reg/wr_mem/dbg addrs, out in_ready/z_out/z_valid/flags/err/dbg data
module pipe_alu_core
  import pipe_alu_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          stall,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [3:0]    func,
  input  logic [AW-1:0] addr,
  input  logic          wr_reg,
  input  logic          wr_mem,
  output logic [DW-1:0] z_out,
  output logic          z_valid,
  output logic [3:0]    flags,
  output logic          err,
  input  logic [RW-1:0] dbg_reg_addr,
  output logic [DW-1:0] dbg_reg_data,
  input  logic [AW-1:0] dbg_mem_addr,
  output logic [DW-1:0] dbg_mem_data
);
  typedef struct packed {
    logic v;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic [3:0] func;
    logic [AW-1:0] addr;
    logic wr_reg;
    logic wr_mem;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } s1_t;
  typedef struct packed {
    logic v;
    logic ill;
    logic wr;
    logic wm;
    logic [RW-1:0] rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] res;
    logic [3:0] fl;
  } st_t;
  s1_t s1;
  st_t s2, s3, s2_n;
  logic [DW-1:0] rf [2**RW];
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] op_a, op_b, y;
  logic [3:0] fl;
  logic ill, wb, s4_wm;
  logic [AW-1:0] s4_addr;
  assign in_ready = !stall;
  assign wb = s3.v && s3.wr;
  assign op_a = (s2.v && s2.wr && s2.rd == s1.rs1) ? s2.res : (s3.v && s3.wr && s3.rd == s1.rs1) ? s3.res : s1.a;
  assign op_b = (s2.v && s2.wr && s2.rd == s1.rs2) ? s2.res : (s3.v && s3.wr && s3.rd == s1.rs2) ? s3.res : s1.b;
  pipe_alu_exec #(.DW(DW)) u_exec (
    .func(s1.func),
    .a(op_a),
    .b(op_b),
    .imm(DW'(s1.addr)),
    .y(y),
    .flags(fl),
    .illegal(ill)
  );
  always_comb s2_n = '{v: s1.v, ill: ill, wr: s1.wr_reg && !ill, wm: s1.wr_mem && !ill, rd: s1.rd, addr: s1.addr, res: y, fl: fl};
  // the capture mux covers the writeback happening on the same edge, so distance 3 needs no forwarding
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      z_out <= '0;
      flags <= '0;
      err <= 1'b0;
      z_valid <= 1'b0;
      s4_wm <= 1'b0;
      s4_addr <= '0;
      for (int i = 0; i < 2**RW; i++) rf[RW'(i)] <= '0;
    end else if (!stall) begin
      s1 <= '{v: in_valid, rs1: rs1, rs2: rs2, rd: rd, func: func, addr: addr, wr_reg: wr_reg, wr_mem: wr_mem,
              a: (wb && s3.rd == rs1) ? s3.res : rf[rs1], b: (wb && s3.rd == rs2) ? s3.res : rf[rs2]};
      s2 <= s2_n;
      s3 <= s2;
      z_out <= s3.res;
      flags <= s3.fl;
      err <= s3.v && s3.ill;
      z_valid <= s3.v;
      s4_wm <= s3.v && s3.wm;
      s4_addr <= s3.addr;
      if (wb) rf[s3.rd] <= s3.res;
    end
  always_ff @(posedge clk)
    if (!stall && s4_wm) mem[s4_addr] <= z_out;
  assign dbg_reg_data = rf[dbg_reg_addr];
  assign dbg_mem_data = mem[dbg_mem_addr];
endmodule

// File: tb/tb_pipe_alu_core.sv
// tb_pipe_alu_core: directed and random checks of pipe_alu_core against an in-order architectural model
module tb_pipe_alu_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, stall = 1'b0, wr_reg = 1'b0, wr_mem = 1'b0;
  logic [3:0] rs1 = '0, rs2 = '0, rd = '0, func = '0, dbg_reg_addr = '0;
  logic [7:0] addr = '0, dbg_mem_addr = '0;
  logic in_ready, z_valid, err;
  logic [15:0] z_out, dbg_reg_data, dbg_mem_data;
  logic [3:0] flags;
  logic b_in_valid = 1'b0, b_stall = 1'b0, b_wr_reg = 1'b0, b_wr_mem = 1'b0;
  logic [4:0] b_rs1 = '0, b_rs2 = '0, b_rd = '0, b_dbg_reg_addr = '0;
  logic [3:0] b_func = '0;
  logic [9:0] b_addr = '0, b_dbg_mem_addr = '0;
  logic b_in_ready, b_z_valid, b_err;
  logic [31:0] b_z_out, b_dbg_reg_data, b_dbg_mem_data;
  logic [3:0] b_flags;
  pipe_alu_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr), .wr_reg(wr_reg), .wr_mem(wr_mem),
    .z_out(z_out), .z_valid(z_valid), .flags(flags), .err(err),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data)
  );
  pipe_alu_core #(.DW(32), .RW(5), .AW(10)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .stall(b_stall),
    .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .func(b_func), .addr(b_addr), .wr_reg(b_wr_reg), .wr_mem(b_wr_mem),
    .z_out(b_z_out), .z_valid(b_z_valid), .flags(b_flags), .err(b_err),
    .dbg_reg_addr(b_dbg_reg_addr), .dbg_reg_data(b_dbg_reg_data),
    .dbg_mem_addr(b_dbg_mem_addr), .dbg_mem_data(b_dbg_mem_data)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit v;
    longint res;
    logic [3:0] fl;
    bit err;
  } exp_t;
  exp_t pipe[$];
  exp_t last, bub;
  longint mreg[16];
  longint mmem[256];
  bit mknown[256];
  longint smem[256];
  bit sknown[256];
  int total = 0, bad = 0;
  string cur = "init";
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs, expv);
    end
  endtask
  function automatic void ref_alu(input int f, input longint a, input longint b, input longint imm,
                                  output longint r, output logic [3:0] fl, output bit e);
    longint sa, sb, t;
    bit c, v;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    c = 0;
    v = 0;
    e = 0;
    r = 0;
    case (f)
      0: begin r = (a + b) % 65536; c = (a + b) > 65535; t = sa + sb; v = t > 32767 || t < -32768; end
      1: begin r = (a - b + 65536) % 65536; c = a < b; t = sa - sb; v = t > 32767 || t < -32768; end
      2: r = (a * b) % 65536;
      3: r = a;
      4: r = b;
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: begin r = (65536 - a) % 65536; v = a == 32768; end
      9: begin r = (65536 - b) % 65536; v = b == 32768; end
      10: begin r = a / 2; c = (a % 2) == 1; end
      11: begin r = (a * 2) % 65536; c = a >= 32768; end
      12: r = imm;
      default: e = 1;
    endcase
    fl = {c, v, r >= 32768, r == 0};
  endfunction
  task automatic step(input bit v, input int f, input int a1, input int a2, input int d, input int ad,
                      input bit wr, input bit wm, input bit st);
    exp_t e;
    in_valid = v;
    func = 4'(f);
    rs1 = 4'(a1);
    rs2 = 4'(a2);
    rd = 4'(d);
    addr = 8'(ad);
    wr_reg = wr;
    wr_mem = wm;
    stall = st;
    @(posedge clk);
    if (!st) begin
      e = bub;
      e.v = v;
      if (v) begin
        ref_alu(f, mreg[a1], mreg[a2], longint'(ad), e.res, e.fl, e.err);
        if (!e.err && wr) mreg[d] = e.res;
        if (!e.err && wm) begin
          mmem[ad] = e.res;
          mknown[ad] = 1;
        end
      end
      pipe.push_back(e);
      if (pipe.size() > 3) last = pipe.pop_front();
    end
    #1;
    chk("in_ready", in_ready, st ? 1'b0 : 1'b1);
    chk("z_valid", z_valid, last.v);
    if (last.v) begin
      chk("z_out", z_out, last.res);
      chk("flags", flags, last.fl);
      chk("err", err, last.err);
    end
  endtask
  task automatic drain();
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic check_state();
    for (int i = 0; i < 16; i++) begin
      dbg_reg_addr = 4'(i);
      #1;
      chk($sformatf("r%0d", i), dbg_reg_data, mreg[i]);
    end
    for (int i = 0; i < 256; i++)
      if (mknown[i]) begin
        dbg_mem_addr = 8'(i);
        #1;
        chk($sformatf("mem%0d", i), dbg_mem_data, mmem[i]);
      end
    @(negedge clk);
  endtask
  task automatic rd_reg(input string tag, input int i, input longint expv);
    dbg_reg_addr = 4'(i);
    #1;
    chk(tag, dbg_reg_data, expv);
  endtask
  task automatic rd_mem(input string tag, input int i, input longint expv);
    dbg_mem_addr = 8'(i);
    #1;
    chk(tag, dbg_mem_data, expv);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_z_valid", z_valid, 0);
    chk("rst_z_out", z_out, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    rd_reg("rst_r7", 7, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mreg[i] = 0;
    pipe.delete();
    repeat (3) pipe.push_back(bub);
    last = bub;
  endtask
  task automatic bstep(input bit v, input int f, input int a1, input int a2, input int d, input int ad,
                       input bit wr, input bit wm);
    b_in_valid = v;
    b_func = 4'(f);
    b_rs1 = 5'(a1);
    b_rs2 = 5'(a2);
    b_rd = 5'(d);
    b_addr = 10'(ad);
    b_wr_reg = wr;
    b_wr_mem = wm;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bub = '{0, 0, 4'h0, 0};
    for (int i = 0; i < 256; i++) mknown[i] = 0;
    #1;
    cur = "reset";
    do_reset();
    cur = "fwd_chain";
    step(1, 12, 0, 0, 3, 3, 1, 0, 0);
    step(1, 12, 0, 0, 5, 5, 1, 0, 0);
    step(1, 0, 3, 5, 10, 125, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("z3", z_out, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("z5", z_out, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("z8", z_out, 8);
    chk("fl_add", flags, 0);
    drain();
    rd_reg("r10", 10, 8);
    rd_mem("mem125", 125, 8);
    check_state();
    cur = "arith";
    step(1, 12, 0, 0, 1, 255, 1, 0, 0);
    step(1, 2, 1, 1, 2, 0, 1, 0, 0);
    step(1, 0, 2, 2, 3, 0, 1, 0, 0);
    step(1, 12, 0, 0, 4, 0, 1, 0, 0);
    step(1, 1, 4, 1, 5, 0, 1, 0, 0);
    step(1, 12, 0, 0, 6, 128, 1, 0, 0);
    step(1, 2, 6, 6, 6, 0, 1, 0, 0);
    step(1, 11, 6, 0, 6, 0, 1, 0, 0);
    step(1, 11, 6, 0, 8, 0, 1, 0, 0);
    drain();
    rd_reg("mul", 2, 16'hFE01);
    rd_reg("add", 3, 16'hFC02);
    rd_reg("sub", 5, 16'hFF01);
    rd_reg("sll", 8, 0);
    check_state();
    cur = "stall";
    step(1, 0, 3, 5, 11, 60, 1, 1, 0);
    step(1, 0, 11, 11, 12, 61, 1, 1, 0);
    step(1, 12, 1, 1, 11, 200, 1, 1, 1);
    step(1, 7, 2, 3, 12, 201, 1, 1, 1);
    step(1, 0, 12, 3, 13, 62, 1, 1, 0);
    step(1, 0, 13, 13, 14, 63, 1, 1, 0);
    drain();
    check_state();
    cur = "illegal";
    step(1, 12, 0, 0, 7, 77, 1, 0, 0);
    step(1, 12, 0, 0, 9, 40, 1, 1, 0);
    step(1, 0, 9, 9, 9, 50, 1, 1, 0);
    step(1, 14, 1, 2, 7, 40, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("ill_z", z_out, 0);
    chk("ill_err", err, 1);
    chk("ill_flags", flags, 4'b0001);
    drain();
    rd_reg("r7_kept", 7, 77);
    rd_mem("mem40_kept", 40, 40);
    check_state();
    cur = "rst_midflight";
    smem = mmem;
    sknown = mknown;
    step(1, 12, 0, 0, 7, 50, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    mmem = smem;
    mknown = sknown;
    repeat (5) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rd_reg("r7_zero", 7, 0);
    rd_mem("mem50_kept", 50, 80);
    check_state();
    cur = "bubbles";
    for (int i = 0; i < 10; i++) step(i % 2 == 0, 12, 0, 0, 15, i + 1, 1, 0, 0);
    drain();
    check_state();
    cur = "random";
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 4) != 0, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
    drain();
    check_state();
    cur = "wide";
    bstep(1, 12, 0, 0, 3, 3, 1, 0);
    bstep(1, 12, 0, 0, 5, 5, 1, 0);
    bstep(1, 0, 3, 5, 31, 1000, 1, 1);
    bstep(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b_v3", b_z_valid, 1);
    chk("b_z3", b_z_out, 3);
    bstep(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b_z5", b_z_out, 5);
    bstep(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b_v8", b_z_valid, 1);
    chk("b_z8", b_z_out, 8);
    chk("b_fl", b_flags, 0);
    bstep(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b_idle", b_z_valid, 0);
    b_dbg_reg_addr = 5'd31;
    b_dbg_mem_addr = 10'd1000;
    #1;
    chk("b_r31", b_dbg_reg_data, 8);
    chk("b_mem1000", b_dbg_mem_data, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
